muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair for the MIPS core. The decoder issues MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start/busy/done handshake. The unit iterates a shift-add multiplier or restoring divider, one bit per cycle. While an operation is in flight it raises a stall for any MFHI/MFLO, which the decoder gates against the main ALU result mux.

Parameters:
WIDTH, 32, operand width; iteration count per operation equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  issue request, sampled on rising clk
op  input  3  operation code (package constants)
opA  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
opB  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  cancel in-flight operation (branch/exception squash)
mf_req  input  1  decoder currently holds MFHI or MFLO
busy  output  1  operation in flight; new start ignored
done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV
stall  output  1  busy & mf_req, combinational
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Async reset (rst_n=0): state IDLE; hi=0, lo=0, busy=0, done=0; internal accumulator, counter and sign flags cleared. Reset mid-operation abandons it with no HI/LO write.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}: latch operands. For signed ops, latch absolute values plus result-sign and remainder-sign flags. Counter=WIDTH-1; go to CALC; busy=1 from the next cycle.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) <= opA at that edge. Stay in IDLE; no busy, no done.
- IDLE, start=1, any other op: ignored.
- CALC: one iteration per cycle (multiply: conditional add + shift; divide: trial subtract + shift). Counter decrements; at counter=0 go to FIX.
- FIX: apply two's-complement sign correction. Load hi/lo at the end-of-FIX edge; done<=1; go to IDLE.
- Latency: start accepted at edge T; CALC occupies cycles T+1..T+WIDTH; FIX at T+WIDTH+1; done high and new hi/lo visible at T+WIDTH+2 (34 cycles for WIDTH=32). busy high for cycles T+1..T+WIDTH+1.
- start while busy: ignored; decoder must hold. No queueing.
- flush: in CALC or FIX, return to IDLE next edge; no HI/LO write, no done. flush in IDLE has no effect. If start and flush are both high in IDLE, flush wins and nothing is accepted.
- Multiply: HI = upper WIDTH bits of the 2*WIDTH-bit product, LO = lower bits. MULT is signed; MULTU is unsigned.
- Divide: LO = quotient, HI = remainder. Signed division truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (opB=0): LO = all ones, HI = opA, normal latency, no error flag.
- Signed overflow (DIV of most-negative by -1): LO = most-negative, HI = 0.
- hi/lo hold their value between updates; MFHI/MFLO read them directly once stall=0.

Decomposition:
- Shared package (mips_pkg): op encodings MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5; FSM state encodings.
- One sub-module muldiv_iter: the combinational single-step datapath (add/shift or subtract/shift over the accumulator). The FSM, counter, sign handling and HI/LO registers stay in muldiv_ctrl.

Test Plan:
- Reset mid-CALC: start MULT, assert rst_n=0 at cycle 10 -> busy=0, done=0, hi=lo=0 immediately; no done pulse afterwards.
- MULT -3 x 7: done exactly 34 cycles after the start edge -> hi=FFFFFFFF, lo=FFFFFFEB. MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- DIVU 100/7 -> lo=0000000E, hi=00000002. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- DIVU 1234/0 -> lo=FFFFFFFF, hi=000004D2, done after 34 cycles.
- Start MULT, hold mf_req=1 throughout -> stall=1 for cycles T+1..T+33, 0 at T+34. A second start at T+5 is ignored (result matches the first operation only).
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> hi/lo updated on each edge, busy never rises, done stays 0. Flush at cycle T+20 of a DIV -> hi/lo unchanged, no done.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: multiply/divide op encodings and sequencer state encodings
package mips_pkg;
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_e;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one shift-add multiply or restoring-divide step over the {acc_h,acc_l} accumulator
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc_h,
    input  logic [WIDTH-1:0] acc_l,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] nxt_h,
    output logic [WIDTH-1:0] nxt_l
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    always_comb begin
        sum   = {1'b0, acc_h} + (acc_l[0] ? {1'b0, b} : '0);
        sh    = {acc_h, acc_l[WIDTH-1]};
        // partial remainder stays below 2*b, so the top bit of diff is the borrow
        diff  = sh - {1'b0, b};
        nxt_h = div ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        nxt_l = div ? {acc_l[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], acc_l[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/DIV sequencer owning the HI/LO register pair
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    input  logic             mf_req,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    md_state_e state, state_nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] acc_h, acc_l, b_q, nxt_h, nxt_l, a_abs, b_abs;
    logic [2*WIDTH-1:0] prod;
    logic div_q, neg_q, neg_r, is_md, a_neg, b_neg, accept;
    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .div  (div_q),
        .acc_h(acc_h),
        .acc_l(acc_l),
        .b    (b_q),
        .nxt_h(nxt_h),
        .nxt_l(nxt_l)
    );
    always_comb begin
        is_md     = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
        accept    = state == IDLE && start && !flush;
        a_neg     = (op == MD_MULT || op == MD_DIV) && opA[WIDTH-1];
        b_neg     = (op == MD_MULT || op == MD_DIV) && opB[WIDTH-1];
        a_abs     = a_neg ? -opA : opA;
        b_abs     = b_neg ? -opB : opB;
        prod      = {acc_h, acc_l};
        state_nxt = flush ? IDLE
                  : state == IDLE ? (start && is_md ? CALC : IDLE)
                  : state == CALC ? (cnt == '0 ? FIX : CALC)
                  : IDLE;
    end
    assign busy  = state != IDLE;
    assign stall = busy & mf_req;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            acc_h <= '0;
            acc_l <= '0;
            b_q   <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            done <= state == FIX && !flush;
            if (accept) begin
                if (op == MD_MTHI) hi <= opA;
                if (op == MD_MTLO) lo <= opA;
                if (is_md) begin
                    div_q <= op == MD_DIV || op == MD_DIVU;
                    // zero divisor keeps the quotient unsigned so it reads all ones
                    neg_q <= (a_neg ^ b_neg) && (|opB);
                    neg_r <= a_neg;
                    acc_h <= '0;
                    acc_l <= a_abs;
                    b_q   <= b_abs;
                    cnt   <= CW'(WIDTH - 1);
                end
            end else if (state == CALC) begin
                acc_h <= nxt_h;
                acc_l <= nxt_l;
                cnt   <= cnt - CW'(1);
            end else if (state == FIX && !flush) begin
                if (div_q) begin
                    lo <= neg_q ? -acc_l : acc_l;
                    hi <= neg_r ? -acc_h : acc_h;
                end else begin
                    {hi, lo} <= neg_q ? -prod : prod;
                end
            end
        end
    end
endmodule
